// File: rtl/button_frontend_pkg.sv
// -----------------------------------------------------------------------------
// menu_pkg: constants and types shared by the button front end and the menu
// FSM that consumes its events.
//   NUM_BTN      : number of board buttons (AD, AT, SEL, CLC)
//   ev_code_t    : 2-bit event code carried on the event channel
//   EV_*         : event codes, equal to the button's bit index
//   deb_state_t  : per-button debounce FSM states
//   pick_t       : result of the priority pick over the pending register
//   pick_pending : highest-priority pending button, CLC > SEL > AT > AD
// -----------------------------------------------------------------------------
package menu_pkg;

    localparam int NUM_BTN = 4;

    typedef logic [1:0] ev_code_t;

    localparam ev_code_t EV_AD  = 2'd0;
    localparam ev_code_t EV_AT  = 2'd1;
    localparam ev_code_t EV_SEL = 2'd2;
    localparam ev_code_t EV_CLC = 2'd3;

    typedef enum logic [1:0] {
        DB_IDLE    = 2'd0,
        DB_PRESS   = 2'd1,
        DB_PRESSED = 2'd2,
        DB_REL     = 2'd3
    } deb_state_t;

    typedef struct packed {
        logic     found;
        ev_code_t code;
    } pick_t;

    // Highest-priority set bit of the pending register; found=0 when empty.
    function automatic pick_t pick_pending(input logic [NUM_BTN-1:0] pend);
        pick_t p;
        p.found = 1'b1;
        if (pend[3]) begin
            p.code = EV_CLC;
        end else if (pend[2]) begin
            p.code = EV_SEL;
        end else if (pend[1]) begin
            p.code = EV_AT;
        end else if (pend[0]) begin
            p.code = EV_AD;
        end else begin
            p.found = 1'b0;
            p.code  = EV_AD;
        end
        return p;
    endfunction

endpackage

// File: rtl/button_frontend_if.sv
// -----------------------------------------------------------------------------
// button_frontend_if: valid/ready event channel from the button front end to
// the menu FSM.
//   ev_valid : an event is presented (producer -> consumer)
//   ev_code  : event code, see menu_pkg::EV_* (producer -> consumer)
//   ev_drop  : one-cycle pulse, a press was merged into an already pending one
//   ev_ready : consumer accepts the presented event (consumer -> producer)
// Modports: master = producer (button_frontend), slave = consumer.
// -----------------------------------------------------------------------------
interface button_frontend_if;
    import menu_pkg::*;

    logic     ev_valid;
    ev_code_t ev_code;
    logic     ev_drop;
    logic     ev_ready;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_drop,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_drop,
        output ev_ready
    );

endinterface

// File: rtl/button_frontend_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce: one button's synchroniser, debounce counter and 4-state FSM.
//   clk       in  system clock
//   reset     in  synchronous active-low reset
//   i_raw     in  asynchronous active-high pin
//   o_level   out debounced level (registered)
//   o_press   out one-cycle pulse, the FSM enters PRESSED from the press side
//   o_pressed out FSM is in PRESSED (used for auto-repeat timing)
// A level change is accepted after DEBOUNCE_CYCLES consecutive samples of the
// synchronised pin that differ from the current level; any bounce restarts it.
// -----------------------------------------------------------------------------
module btn_debounce
    import menu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 160000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_pressed
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic             w_differ;
    logic             w_done;
    logic             w_press;

    // The count completes on the edge where D consecutive differing samples
    // have been seen; the level and the FSM both move on that edge.
    assign w_differ = (r_sync2 != r_level);
    assign w_done   = w_differ && (r_cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter and debounced level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_done) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else if (w_differ) begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt   <= '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= DB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and press pulse. Only the press side produces an event;
    // a release bounce returning to PRESSED is not a new press.
    always_comb begin
        w_state_nxt = r_state;
        w_press     = 1'b0;
        case (r_state)
            DB_IDLE: begin
                if (r_sync2) begin
                    if (w_done) begin
                        w_state_nxt = DB_PRESSED;
                        w_press     = 1'b1;
                    end else begin
                        w_state_nxt = DB_PRESS;
                    end
                end else begin
                    w_state_nxt = DB_IDLE;
                end
            end
            DB_PRESS: begin
                if (w_done) begin
                    w_state_nxt = DB_PRESSED;
                    w_press     = 1'b1;
                end else if (!r_sync2) begin
                    w_state_nxt = DB_IDLE;
                end else begin
                    w_state_nxt = DB_PRESS;
                end
            end
            DB_PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt = w_done ? DB_IDLE : DB_REL;
                end else begin
                    w_state_nxt = DB_PRESSED;
                end
            end
            DB_REL: begin
                if (w_done) begin
                    w_state_nxt = DB_IDLE;
                end else if (r_sync2) begin
                    w_state_nxt = DB_PRESSED;
                end else begin
                    w_state_nxt = DB_REL;
                end
            end
            default: begin
                w_state_nxt = DB_IDLE;
                w_press     = 1'b0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = w_press;
    assign o_pressed = (r_state == DB_PRESSED);

endmodule

// File: rtl/button_frontend.sv
// -----------------------------------------------------------------------------
// button_frontend: debounces the four board buttons and turns each press into
// exactly one event on a valid/ready channel towards the menu FSM.
//   clk       in  system clock, rising edge
//   reset     in  synchronous active-low reset
//   btn_raw   in  [3:0] asynchronous pins: [0]=AD [1]=AT [2]=SEL [3]=CLC
//   btn_level out [3:0] debounced levels
//   ev_if     master modport of button_frontend_if (ev_valid, ev_code,
//             ev_drop out; ev_ready in)
// Optional feature: define AUTOREPEAT_EN to make AD and AT auto-repeat while
// held (first repeat REPEAT_DELAY cycles after the press event, then every
// REPEAT_PERIOD cycles). Without it each press yields exactly one event.
// -----------------------------------------------------------------------------
module button_frontend
    import menu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 160000,
    parameter int unsigned REPEAT_DELAY    = 8000000,
    parameter int unsigned REPEAT_PERIOD   = 3200000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  btn_raw,
    output logic [NUM_BTN-1:0]  btn_level,
    button_frontend_if.master   ev_if
);

`ifdef AUTOREPEAT_EN
    localparam logic RPT_EN = 1'b1;
`else
    localparam logic RPT_EN = 1'b0;
`endif

    // Auto-repeat applies to AD and AT only.
    localparam logic [NUM_BTN-1:0] RPT_MASK = 4'b0011;

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_pressed;

    logic [RPT_W-1:0]   r_rpt_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] r_rpt_first;
    logic [NUM_BTN-1:0] w_rpt_active;
    logic [NUM_BTN-1:0] w_repeat;

    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] w_pending_nxt;
    logic [NUM_BTN-1:0] w_event;
    logic [NUM_BTN-1:0] w_clr;
    logic               w_load;
    logic               w_drop;
    pick_t              w_pick;

    logic               r_valid;
    ev_code_t           r_code;
    logic               r_drop;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .i_raw     (btn_raw[gi]),
            .o_level   (w_level[gi]),
            .o_press   (w_press[gi]),
            .o_pressed (w_pressed[gi])
        );
    end

    assign btn_level = w_level;

    // Repeat fire decision: first repeat after REPEAT_DELAY cycles in PRESSED,
    // later ones every REPEAT_PERIOD cycles.
    always_comb begin
        w_rpt_active = '0;
        w_repeat     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_rpt_active[i] = RPT_EN & RPT_MASK[i] & w_pressed[i];
            if (!w_rpt_active[i]) begin
                w_repeat[i] = 1'b0;
            end else if (r_rpt_first[i]) begin
                w_repeat[i] = (r_rpt_cnt[i] == RPT_DELAY_LAST);
            end else begin
                w_repeat[i] = (r_rpt_cnt[i] == RPT_PERIOD_LAST);
            end
        end
    end

    // Repeat counters: run while in PRESSED, clear on leaving it and on each
    // repeat event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_rpt_cnt[i] <= '0;
            end
            r_rpt_first <= '1;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!w_rpt_active[i]) begin
                    r_rpt_cnt[i]   <= '0;
                    r_rpt_first[i] <= 1'b1;
                end else if (w_repeat[i]) begin
                    r_rpt_cnt[i]   <= '0;
                    r_rpt_first[i] <= 1'b0;
                end else begin
                    r_rpt_cnt[i]   <= r_rpt_cnt[i] + RPT_W'(1);
                    r_rpt_first[i] <= r_rpt_first[i];
                end
            end
        end
    end

    // Arbitration and pending update. The stage picks from the registered
    // pending bits, so a press arriving on the same edge that its bit is
    // loaded survives as a fresh pending bit rather than being merged.
    always_comb begin
        w_event = w_press | w_repeat;
        w_pick  = pick_pending(r_pending);
        w_load  = !r_valid || ev_if.ev_ready;
        w_clr   = '0;
        if (w_load && w_pick.found) begin
            w_clr = 4'b0001 << w_pick.code;
        end else begin
            w_clr = '0;
        end
        w_drop        = |(w_event & r_pending & ~w_clr);
        w_pending_nxt = (r_pending & ~w_clr) | w_event;
    end

    // Pending register, output stage and drop pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_code    <= EV_AD;
            r_drop    <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_drop    <= w_drop;
            if (w_load) begin
                r_valid <= w_pick.found;
                if (w_pick.found) begin
                    r_code <= w_pick.code;
                end else begin
                    r_code <= r_code;
                end
            end else begin
                r_valid <= r_valid;
                r_code  <= r_code;
            end
        end
    end

    assign ev_if.ev_valid = r_valid;
    assign ev_if.ev_code  = r_code;
    assign ev_if.ev_drop  = r_drop;

endmodule

// File: tb/tb_button_frontend.sv
// -----------------------------------------------------------------------------
// tb_button_frontend: directed scenarios plus randomized pin/ready traffic,
// checked every cycle against a behavioural model (pin delayed two samples,
// level = value held for DEBOUNCE_CYCLES samples, events queued by priority).
// Edge numbering in the scenarios: edge 0 is the edge just before the pins
// change; inputs are driven 1 time unit after an edge.
// -----------------------------------------------------------------------------
module tb_button_frontend;
    import menu_pkg::*;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] btn_level;

    button_frontend_if ev_if ();

    button_frontend #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .ev_if     (ev_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         m_d1 [4];
    logic         m_d2 [4];
    logic         m_s_prev [4];
    logic [D-1:0] m_hist [4];
    int           m_nh [4];
    int           m_age [4];
    logic [3:0]   m_level   = 4'b0000;
    logic [3:0]   m_pending = 4'b0000;
    logic         m_valid   = 1'b0;
    logic [1:0]   m_code    = 2'd0;
    logic         m_drop    = 1'b0;

    task automatic model_clear();
        for (int b = 0; b < 4; b++) begin
            m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_s_prev[b] = 1'b0;
            m_hist[b] = '0; m_nh[b] = 0; m_age[b] = 0;
        end
        m_level = 4'b0000; m_pending = 4'b0000;
        m_valid = 1'b0; m_code = 2'd0; m_drop = 1'b0;
    endtask

    // One clock edge, using the input values present at that edge.
    task automatic model_step();
        logic [3:0] ev;
        logic [3:0] clr;
        logic       s;
        logic       held;
        bit         found;
        ev = 4'b0000; clr = 4'b0000; found = 0;
        if (!reset) begin
            model_clear();
            return;
        end
        for (int b = 0; b < 4; b++) begin
            s    = m_d2[b];
            held = m_level[b] && m_s_prev[b];
            m_age[b] = held ? m_age[b] + 1 : 0;
`ifdef AUTOREPEAT_EN
            if (b < 2 && held && (m_age[b] == RD || (m_age[b] > RD && (m_age[b] - RD) % RP == 0)))
                ev[b] = 1'b1;
`endif
            m_hist[b] = {m_hist[b][D-2:0], s};
            if (m_nh[b] < D) m_nh[b]++;
            if (m_nh[b] == D && m_hist[b] == {D{~m_level[b]}}) begin
                if (!m_level[b]) ev[b] = 1'b1;
                m_level[b] = ~m_level[b];
                m_nh[b] = 0;
            end
            m_s_prev[b] = s;
            m_d2[b] = m_d1[b];
            m_d1[b] = btn_raw[b];
        end
        if (!m_valid || ev_if.ev_ready) begin
            for (int b = 3; b >= 0; b--) begin
                if (!found && m_pending[b]) begin
                    found = 1;
                    m_code = 2'(b);
                    clr[b] = 1'b1;
                end
            end
            m_valid = found;
        end
        m_drop    = |(ev & m_pending & ~clr);
        m_pending = (m_pending & ~clr) | ev;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("mdl_level", btn_level, m_level);
            chk("mdl_valid", ev_if.ev_valid, m_valid);
            if (m_valid) chk("mdl_code", ev_if.ev_code, m_code);
            chk("mdl_drop", ev_if.ev_drop, m_drop);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int hold [4];

    initial begin
        ev_if.ev_ready = 1'b1;
        step(3);
        chk("rst_level", btn_level, 4'b0000);
        chk("rst_valid", ev_if.ev_valid, 1'b0);
        chk("rst_code",  ev_if.ev_code, 2'd0);
        chk("rst_drop",  ev_if.ev_drop, 1'b0);
        reset = 1'b1;
        step(5);

        // Clean SEL press held 10 cycles.
        btn_raw[2] = 1'b1;
        step(5);  chk("sel_lvl_e5", btn_level[2], 1'b0);
        step(1);  chk("sel_lvl_e6", btn_level[2], 1'b1);
                  chk("sel_val_e6", ev_if.ev_valid, 1'b0);
        step(1);  chk("sel_val_e7", ev_if.ev_valid, 1'b1);
                  chk("sel_code_e7", ev_if.ev_code, EV_SEL);
        step(1);  chk("sel_val_e8", ev_if.ev_valid, 1'b0);
        step(2);
        btn_raw[2] = 1'b0;
        step(12);

        // AD bouncing every 2 cycles, then held.
        for (int i = 0; i < 6; i++) begin
            btn_raw[0] = (i % 2 == 0);
            step(2);
            chk("ad_bounce_noev", ev_if.ev_valid, 1'b0);
        end
        btn_raw[0] = 1'b1;
        step(6);  chk("ad_val_e6", ev_if.ev_valid, 1'b0);
        step(1);  chk("ad_val_e7", ev_if.ev_valid, 1'b1);
                  chk("ad_code_e7", ev_if.ev_code, EV_AD);
        step(1);  chk("ad_val_e8", ev_if.ev_valid, 1'b0);
        btn_raw[0] = 1'b0;
        step(12);

        // AD and CLC together with the consumer stalled for 10 cycles.
        ev_if.ev_ready = 1'b0;
        btn_raw = 4'b1001;
        step(7);  chk("pri_val_e7", ev_if.ev_valid, 1'b1);
                  chk("pri_code_e7", ev_if.ev_code, EV_CLC);
        step(3);  chk("pri_code_e10", ev_if.ev_code, EV_CLC);
        ev_if.ev_ready = 1'b1;
        step(1);  chk("pri_val_e11", ev_if.ev_valid, 1'b1);
                  chk("pri_code_e11", ev_if.ev_code, EV_AD);
        step(1);  chk("pri_val_e12", ev_if.ev_valid, 1'b0);
        btn_raw = 4'b0000;
        step(12);

        // Stalled consumer, SEL pressed twice more: merge then drop.
        ev_if.ev_ready = 1'b0;
        btn_raw[2] = 1'b1;
        step(7);  chk("drp_code", ev_if.ev_code, EV_SEL);
        btn_raw[2] = 1'b0;
        step(10);
        btn_raw[2] = 1'b1;
        step(6);  chk("drp_first_nodrop", ev_if.ev_drop, 1'b0);
        btn_raw[2] = 1'b0;
        step(10);
        btn_raw[2] = 1'b1;
        step(5);  chk("drp_e5", ev_if.ev_drop, 1'b0);
        step(1);  chk("drp_e6", ev_if.ev_drop, 1'b1);
        step(1);  chk("drp_e7", ev_if.ev_drop, 1'b0);
                  chk("drp_held", ev_if.ev_code, EV_SEL);
        ev_if.ev_ready = 1'b1;
        step(1);  chk("drp_next_val", ev_if.ev_valid, 1'b1);
                  chk("drp_next_code", ev_if.ev_code, EV_SEL);
        step(1);  chk("drp_empty", ev_if.ev_valid, 1'b0);
        btn_raw[2] = 1'b0;
        step(12);

        // Reset while AT is mid-debounce and an event is presented.
        ev_if.ev_ready = 1'b0;
        btn_raw[2] = 1'b1;
        step(7);  chk("rr_presented", ev_if.ev_valid, 1'b1);
        btn_raw[1] = 1'b1;
        step(3);
        reset = 1'b0;
        btn_raw[2] = 1'b0;
        step(1);
        chk("rr_level", btn_level, 4'b0000);
        chk("rr_valid", ev_if.ev_valid, 1'b0);
        chk("rr_code",  ev_if.ev_code, 2'd0);
        chk("rr_drop",  ev_if.ev_drop, 1'b0);
        reset = 1'b1;
        ev_if.ev_ready = 1'b1;
        step(6);  chk("rr_val_e6", ev_if.ev_valid, 1'b0);
        step(1);  chk("rr_val_e7", ev_if.ev_valid, 1'b1);
                  chk("rr_code_e7", ev_if.ev_code, EV_AT);
        step(1);  chk("rr_val_e8", ev_if.ev_valid, 1'b0);
        btn_raw[1] = 1'b0;
        step(12);

        // AT held after its press event: auto-repeat only with the macro.
        btn_raw[1] = 1'b1;
        step(7);  chk("rpt_press", ev_if.ev_valid, 1'b1);
        for (int k = 1; k <= 64; k++) begin
            logic exp_v;
            step(1);
`ifdef AUTOREPEAT_EN
            exp_v = (k == 20 || k == 28 || k == 36 || k == 44 || k == 52);
`else
            exp_v = 1'b0;
`endif
            chk($sformatf("rpt_k%0d", k), ev_if.ev_valid, exp_v);
            if (k == 53) btn_raw[1] = 1'b0;
        end
        step(12);

        // Randomized pins, consumer pacing and occasional reset.
        for (int b = 0; b < 4; b++) hold[b] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    btn_raw[b] = 1'($urandom_range(0, 1));
                    hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 3);
                end else begin
                    hold[b]--;
                end
            end
            ev_if.ev_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 599) != 0);
            step(1);
        end
        reset = 1'b1;
        btn_raw = 4'b0000;
        ev_if.ev_ready = 1'b1;
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
